sdram_arbit: RTL and testbench
==============================

# sdram_arbit

SDRAM command arbiter sitting directly downstream of the init, refresh, write (`sdram_write`) and read engines, and upstream of the SDRAM pins. It grants exactly one engine ownership of the command bus at a time (refresh > write > read), returns a one-cycle enable pulse to the granted engine, and multiplexes that engine's command, address, bank and data onto the device pins until the engine signals its end. A watchdog reclaims the bus if an owner never ends.

## Interface
- `TIMEOUT`, 1023: maximum cycles in an owner state before forced return to ARBIT.
- `sclk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `init_end`  in  1  level; init sequence complete (stays high).
- `init_cmd`/`init_addr`  in  4/13  init engine command/address.
- `ref_req`, `ref_end`  in  1  refresh request (level) / end (pulse).
- `ref_cmd`/`ref_addr`  in  4/13  refresh engine command/address.
- `ref_en`  out  1  refresh grant pulse.
- `wr_req`, `wr_end`  in  1  write request (level) / end (pulse, from `flag_wr_end`).
- `wr_cmd`/`wr_addr`/`wr_bank`/`wr_data`  in  4/13/2/16  write engine outputs.
- `wr_en`  out  1  write grant pulse.
- `rd_req`, `rd_end`  in  1  read request / end.
- `rd_cmd`/`rd_addr`/`rd_bank`  in  4/13/2  read engine outputs.
- `rd_en`  out  1  read grant pulse.
- `sdram_cke`  out  1  constant 1 after reset.
- `sdram_cs_n`,`sdram_ras_n`,`sdram_cas_n`,`sdram_we_n`  out  1 each  = selected cmd bits [3:0].
- `sdram_ba`  out  2  selected bank.
- `sdram_addr`  out  13  selected address.
- `sdram_dq_out`  out  16  `wr_data` pass-through.
- `sdram_dq_oe`  out  1  drive enable for DQ.
- `err_timeout`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- States: INIT, ARBIT, AREF, WRITE, READ (one-hot).
- INIT: mux init_cmd/init_addr, ba=0; on `init_end`=1 → ARBIT.
- ARBIT: cmd NOP (0111), addr 0, ba 0. Priority ref_req → AREF, else wr_req → WRITE, else rd_req → READ, else stay. Simultaneous requests: highest priority only.
- Owner states mux that engine's cmd/addr/bank (refresh bank 0). Exit to ARBIT the cycle after the matching `*_end`=1; other engines' `*_end` ignored.
- Enables: registered, asserted exactly in the first cycle of the owner state, never otherwise.
- `sdram_dq_oe` = 1 only in WRITE.
- Watchdog: counter cleared in ARBIT/INIT, increments each cycle in an owner state; when it reaches TIMEOUT without end → ARBIT next cycle, `err_timeout` pulse, counter clears. End and timeout in same cycle: end wins, no error.
- Reset (any time, incl. mid-burst): state INIT, enables 0, err 0, cmd NOP, addr 0, ba 0, dq_oe 0, cke 1.

## Timing
- Grant latency: request seen in ARBIT cycle N → owner state and `*_en`=1 at N+1.
- Mux outputs combinational on current state: engine cmd at cycle K appears on pins at cycle K (zero added latency).
- Release: `*_end` at cycle M → ARBIT at M+1 (NOP on pins) → earliest next grant at M+2.
- Minimum one ARBIT cycle between any two owners; back-to-back write-refresh-write holds pins NOP for that cycle.
- Watchdog width: clog2(TIMEOUT+1) bits, no wrap (saturates via exit).

## Structure
- Shared package `sdram_pkg`: command constants (NOP 0111, PRE 0010, AREF 0001, ACT 0011, WR 0100, RD 0101), state encoding, address/bank/data widths.
- One sub-module: `sdram_arbit_wdog` (timeout counter with clear/enable, expiry pulse).

## Test plan
- Reset held 3 cycles mid-WRITE → next cycle state INIT, all pins NOP, wr_en 0, dq_oe 0.
- init_end rises at cycle 10 with wr_req=1 → ARBIT cycle 11, WRITE + wr_en pulse cycle 12, pins show wr_cmd 0011 same cycle writer issues ACT.
- ref_req, wr_req, rd_req all 1 in ARBIT → ref_en only; after ref_end, wr_en granted 2 cycles later; rd waits.
- Writer pulses wr_end during refresh-preempt (S_PRE, ref_req=1) → ARBIT next cycle, then AREF with ref_en, then WRITE re-granted after ref_end.
- TIMEOUT=8, READ granted, rd_end never asserted → ARBIT after 8 owner cycles, err_timeout 1 cycle, rd_en not re-pulsed unless rd_req still high.
- wr_end and timeout coincide → ARBIT, err_timeout stays 0.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {cs_n,ras_n,cas_n,we_n},
// arbiter state encoding, pin bus widths and the muxed pin-bus payload.
package sdram_pkg;

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned BA_W   = 2;
    localparam int unsigned DQ_W   = 16;

    localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_ACT  = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_WR   = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_RD   = 4'b0101;

    // One-hot arbiter states
    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_ARBIT = 5'b00010,
        S_AREF  = 5'b00100,
        S_WRITE = 5'b01000,
        S_READ  = 5'b10000
    } state_e;

    // Command/bank/address bundle driven onto the SDRAM pins
    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [BA_W-1:0]   ba;
        logic [ADDR_W-1:0] addr;
    } pin_bus_t;

    localparam pin_bus_t BUS_IDLE = '{cmd: CMD_NOP, ba: '0, addr: '0};

    function automatic pin_bus_t mk_bus(input logic [CMD_W-1:0]  cmd,
                                        input logic [BA_W-1:0]   ba,
                                        input logic [ADDR_W-1:0] addr);
        pin_bus_t b;
        b.cmd  = cmd;
        b.ba   = ba;
        b.addr = addr;
        return b;
    endfunction

endpackage

// File: rtl/sdram_arbit_wdog.sv
// Owner-state watchdog.
// Ports: clk/reset (sync, active high); en counts owner cycles; clr zeroes
// the count; expire_c is high during the TIMEOUT-th consecutive enabled cycle.
module sdram_arbit_wdog #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count holds cycles already spent; this cycle is the TIMEOUT-th one
    assign expire_c = en && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Expiry forces a clear so the counter never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (clr || expire_c) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: grants the pin bus to init, refresh, write or read
// engine (refresh > write > read), pulses the granted engine's enable in the
// first owner cycle, muxes the owner's cmd/bank/addr to the pins with no added
// latency, and reclaims the bus via a watchdog if an owner never ends.
// Ports: sclk/reset (sync, active high); per-engine cmd/addr/bank/req/end
// inputs; ref_en/wr_en/rd_en grant pulses; SDRAM pin outputs; err_timeout.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic              init_end,
    input  logic [CMD_W-1:0]  init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              ref_req,
    input  logic              ref_end,
    input  logic [CMD_W-1:0]  ref_cmd,
    input  logic [ADDR_W-1:0] ref_addr,
    output logic              ref_en,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [CMD_W-1:0]  wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BA_W-1:0]   wr_bank,
    input  logic [DQ_W-1:0]   wr_data,
    output logic              wr_en,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [CMD_W-1:0]  rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BA_W-1:0]   rd_bank,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DQ_W-1:0]   sdram_dq_out,
    output logic              sdram_dq_oe,
    output logic              err_timeout
);

    state_e   state_q, state_d;
    logic     ref_en_q, ref_en_d;
    logic     wr_en_q,  wr_en_d;
    logic     rd_en_q,  rd_en_d;
    logic     err_q,    err_d;
    logic     cke_q;
    pin_bus_t bus_c;
    logic     owner_c;
    logic     wd_clr_c;
    logic     wd_expire_c;

    // Watchdog runs only while an engine owns the bus
    assign owner_c  = (state_q == S_AREF) || (state_q == S_WRITE) || (state_q == S_READ);
    assign wd_clr_c = (state_d == S_INIT) || (state_d == S_ARBIT);

    sdram_arbit_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (sclk),
        .reset    (reset),
        .en       (owner_c),
        .clr      (wd_clr_c),
        .expire_c (wd_expire_c)
    );

    // Next-state, grant pulses and pin mux
    always_comb begin
        state_d  = state_q;
        ref_en_d = 1'b0;
        wr_en_d  = 1'b0;
        rd_en_d  = 1'b0;
        err_d    = 1'b0;
        bus_c    = BUS_IDLE;

        case (state_q)
            S_INIT: begin
                bus_c = mk_bus(init_cmd, '0, init_addr);
                if (init_end) begin
                    state_d = S_ARBIT;
                end
            end
            S_ARBIT: begin
                if (ref_req) begin
                    state_d  = S_AREF;
                    ref_en_d = 1'b1;
                end else if (wr_req) begin
                    state_d = S_WRITE;
                    wr_en_d = 1'b1;
                end else if (rd_req) begin
                    state_d = S_READ;
                    rd_en_d = 1'b1;
                end
            end
            S_AREF: begin
                bus_c = mk_bus(ref_cmd, '0, ref_addr);
                if (ref_end) begin
                    state_d = S_ARBIT;
                end else if (wd_expire_c) begin
                    state_d = S_ARBIT;
                    err_d   = 1'b1;
                end
            end
            S_WRITE: begin
                bus_c = mk_bus(wr_cmd, wr_bank, wr_addr);
                if (wr_end) begin
                    state_d = S_ARBIT;
                end else if (wd_expire_c) begin
                    state_d = S_ARBIT;
                    err_d   = 1'b1;
                end
            end
            S_READ: begin
                bus_c = mk_bus(rd_cmd, rd_bank, rd_addr);
                if (rd_end) begin
                    state_d = S_ARBIT;
                end else if (wd_expire_c) begin
                    state_d = S_ARBIT;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        // Pins go idle immediately while reset is held, even mid-burst
        if (reset) begin
            bus_c = BUS_IDLE;
        end
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            state_q  <= S_INIT;
            ref_en_q <= 1'b0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            err_q    <= 1'b0;
            cke_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            ref_en_q <= ref_en_d;
            wr_en_q  <= wr_en_d;
            rd_en_q  <= rd_en_d;
            err_q    <= err_d;
            cke_q    <= 1'b1;
        end
    end

    assign ref_en       = ref_en_q;
    assign wr_en        = wr_en_q;
    assign rd_en        = rd_en_q;
    assign err_timeout  = err_q;
    assign sdram_cke    = cke_q;
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = bus_c.cmd;
    assign sdram_ba     = bus_c.ba;
    assign sdram_addr   = bus_c.addr;
    assign sdram_dq_out = wr_data;
    assign sdram_dq_oe  = (state_q == S_WRITE) && !reset;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios followed by random traffic, all
// compared against a cycle-level owner/age reference model.
module tb_sdram_arbit;

    localparam int unsigned TMO = 8;
    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] ACT  = 4'b0011;
    localparam logic [3:0] WRC  = 4'b0100;
    localparam logic [3:0] RDC  = 4'b0101;

    localparam int OW_INIT = 0;
    localparam int OW_ARB  = 1;
    localparam int OW_REF  = 2;
    localparam int OW_WR   = 3;
    localparam int OW_RD   = 4;

    logic        sclk, reset, init_end;
    logic [3:0]  init_cmd, ref_cmd, wr_cmd, rd_cmd;
    logic [12:0] init_addr, ref_addr, wr_addr, rd_addr;
    logic [1:0]  wr_bank, rd_bank;
    logic [15:0] wr_data;
    logic        ref_req, ref_end, wr_req, wr_end, rd_req, rd_end;
    logic        ref_en, wr_en, rd_en;
    logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe, err_timeout;

    logic [3:0]  pin_cmd;
    logic [40:0] obs_vec;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus, how long, and registered outputs
    int m_st;
    int m_age;
    bit m_ref_en, m_wr_en, m_rd_en, m_err, m_valid;

    sdram_arbit #(.TIMEOUT(TMO)) dut (
        .sclk(sclk), .reset(reset), .init_end(init_end),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .ref_req(ref_req), .ref_end(ref_end), .ref_cmd(ref_cmd), .ref_addr(ref_addr), .ref_en(ref_en),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
        .wr_data(wr_data), .wr_en(wr_en),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank), .rd_en(rd_en),
        .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
        .sdram_addr(sdram_addr), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
        .err_timeout(err_timeout)
    );

    assign pin_cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    assign obs_vec = {pin_cmd, sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe, sdram_cke,
                      ref_en, wr_en, rd_en, err_timeout};

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [40:0] expect_vec();
        logic [3:0]  c;
        logic [1:0]  b;
        logic [12:0] a;
        c = NOP; b = 2'd0; a = 13'd0;
        if (!reset) begin
            case (m_st)
                OW_INIT: begin c = init_cmd; a = init_addr; end
                OW_REF:  begin c = ref_cmd;  a = ref_addr; end
                OW_WR:   begin c = wr_cmd;   b = wr_bank; a = wr_addr; end
                OW_RD:   begin c = rd_cmd;   b = rd_bank; a = rd_addr; end
                default: ;
            endcase
        end
        return {c, b, a, wr_data, (!reset && m_st == OW_WR), 1'b1,
                m_ref_en, m_wr_en, m_rd_en, m_err};
    endfunction

    // Advance the model across one rising edge using the current inputs
    function automatic void model_step();
        bit nr, nw, nd, ne, ended;
        nr = 0; nw = 0; nd = 0; ne = 0;
        ended = (m_st == OW_REF && ref_end) || (m_st == OW_WR && wr_end) ||
                (m_st == OW_RD && rd_end);
        if (reset) begin
            m_st = OW_INIT;
            m_age = 0;
            m_valid = 1;
        end else if (m_valid) begin
            if (m_st == OW_INIT) begin
                if (init_end) m_st = OW_ARB;
            end else if (m_st == OW_ARB) begin
                m_age = 0;
                if (ref_req)     begin m_st = OW_REF; nr = 1; end
                else if (wr_req) begin m_st = OW_WR;  nw = 1; end
                else if (rd_req) begin m_st = OW_RD;  nd = 1; end
            end else if (ended) begin
                m_st = OW_ARB;
            end else if (m_age + 1 >= int'(TMO)) begin
                m_st = OW_ARB;
                ne = 1;
            end else begin
                m_age++;
            end
        end
        m_ref_en = nr; m_wr_en = nw; m_rd_en = nd; m_err = ne;
    endfunction

    task automatic look(input string tag);
        #1;
        if (m_valid) chk(tag, 64'(obs_vec), 64'(expect_vec()));
    endtask

    task automatic tick();
        @(posedge sclk);
        model_step();
        #1;
    endtask

    task automatic rnd_buses();
        init_cmd  = 4'($urandom);  init_addr = 13'($urandom);
        ref_cmd   = 4'($urandom);  ref_addr  = 13'($urandom);
        wr_cmd    = 4'($urandom);  wr_addr   = 13'($urandom);
        wr_bank   = 2'($urandom);  wr_data   = 16'($urandom);
        rd_cmd    = 4'($urandom);  rd_addr   = 13'($urandom);
        rd_bank   = 2'($urandom);
    endtask

    initial begin
        m_valid = 0; m_st = OW_INIT; m_age = 0;
        m_ref_en = 0; m_wr_en = 0; m_rd_en = 0; m_err = 0;
        reset = 1'b1; init_end = 1'b0;
        ref_req = 0; ref_end = 0; wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;
        rnd_buses();
        #2;

        // Reset and INIT pass-through
        repeat (3) begin rnd_buses(); look("rst"); tick(); end
        look("rst_hold");
        chk("rst_pins_nop", 64'(pin_cmd), 64'(NOP));
        reset = 1'b0;
        repeat (6) begin
            rnd_buses(); look("init");
            chk("init_mux_addr", 64'(sdram_addr), 64'(init_addr));
            tick();
        end

        // init_end with wr_req pending: ARBIT, then WRITE with wr_en
        init_end = 1'b1; wr_req = 1'b1; init_cmd = NOP;
        look("init_end"); tick();
        look("arbit"); chk("arbit_nop", 64'(pin_cmd), 64'(NOP)); chk("arbit_no_en", 64'(wr_en), 64'(0));
        tick();
        wr_cmd = ACT; look("wr_grant");
        chk("wr_en_pulse", 64'(wr_en), 64'(1));
        chk("wr_act_pins", 64'(pin_cmd), 64'(ACT));
        chk("wr_dq_oe", 64'(sdram_dq_oe), 64'(1));

        // Writer ends during refresh preempt; refresh then write re-granted
        ref_req = 1; wr_cmd = PRE; wr_end = 1;
        look("preempt"); tick();
        wr_end = 0; look("pre_arbit"); chk("pre_arbit_nop", 64'(pin_cmd), 64'(NOP)); tick();
        ref_cmd = AREF; look("aref");
        chk("aref_en", 64'(ref_en), 64'(1)); chk("aref_no_wr", 64'(wr_en), 64'(0));
        chk("aref_pins", 64'(pin_cmd), 64'(AREF));
        ref_end = 1; ref_req = 0; tick();
        ref_end = 0; look("aref_done"); tick();
        look("wr_regrant"); chk("wr_regrant_en", 64'(wr_en), 64'(1));

        // All three requesting: refresh, then write, then read
        wr_end = 1; ref_req = 1; rd_req = 1; tick();
        wr_end = 0; look("all_arbit"); tick();
        look("all_ref");
        chk("all_ref_en", 64'(ref_en), 64'(1)); chk("all_wr0", 64'(wr_en), 64'(0)); chk("all_rd0", 64'(rd_en), 64'(0));
        ref_end = 1; ref_req = 0; tick();
        ref_end = 0; look("all_arb2"); tick();
        look("all_wr"); chk("all_wr_en", 64'(wr_en), 64'(1)); chk("all_rd_wait", 64'(rd_en), 64'(0));
        wr_end = 1; wr_req = 0; tick();
        wr_end = 0; look("all_arb3"); tick();
        rd_cmd = RDC; look("all_rd"); chk("all_rd_en", 64'(rd_en), 64'(1));
        chk("all_rd_pins", 64'(pin_cmd), 64'(RDC));
        rd_end = 1; rd_req = 0; tick();
        rd_end = 0; look("rd_done");

        // Read never ends: watchdog returns to ARBIT after TMO owner cycles
        rd_req = 1; tick();
        rd_req = 0;
        for (int i = 1; i <= int'(TMO); i++) begin
            rnd_buses(); look("to_cycle");
            chk("to_rd_en", 64'(rd_en), 64'(i == 1));
            chk("to_err_low", 64'(err_timeout), 64'(0));
            chk("to_mux_ba", 64'(sdram_ba), 64'(rd_bank));
            tick();
        end
        look("to_expire");
        chk("to_err_pulse", 64'(err_timeout), 64'(1));
        chk("to_arbit_nop", 64'(pin_cmd), 64'(NOP));
        tick();
        look("to_after"); chk("to_err_once", 64'(err_timeout), 64'(0)); chk("to_no_regrant", 64'(rd_en), 64'(0));

        // wr_end coincides with expiry: end wins, no error
        wr_req = 1; look("co_arb"); tick();
        wr_req = 0;
        for (int i = 1; i <= int'(TMO); i++) begin
            wr_end = (i == int'(TMO)); rnd_buses(); look("co_cycle"); tick();
        end
        wr_end = 0; look("co_after");
        chk("co_no_err", 64'(err_timeout), 64'(0)); chk("co_arbit_nop", 64'(pin_cmd), 64'(NOP));

        // Reset held three cycles mid-WRITE
        tick();
        wr_req = 1; look("mid_arb"); tick();
        wr_req = 0; look("mid_wr1"); tick();
        reset = 1;
        repeat (3) begin
            look("mid_rst");
            chk("mid_rst_nop", 64'(pin_cmd), 64'(NOP)); chk("mid_rst_oe", 64'(sdram_dq_oe), 64'(0));
            tick();
        end
        reset = 0; init_end = 0; init_cmd = NOP;
        look("mid_init");
        chk("mid_init_nop", 64'(pin_cmd), 64'(NOP)); chk("mid_init_wr_en", 64'(wr_en), 64'(0));
        chk("mid_init_oe", 64'(sdram_dq_oe), 64'(0)); chk("mid_init_cke", 64'(sdram_cke), 64'(1));
        tick();

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            rnd_buses();
            reset    = ($urandom_range(0, 199) == 0);
            init_end = ($urandom_range(0, 3) != 0);
            ref_req  = ($urandom_range(0, 3) == 0);
            wr_req   = ($urandom_range(0, 1) == 0);
            rd_req   = ($urandom_range(0, 1) == 0);
            ref_end  = ($urandom_range(0, 5) == 0);
            wr_end   = ($urandom_range(0, 6) == 0);
            rd_end   = ($urandom_range(0, 7) == 0);
            look("rand");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
